spmv_row_feeder: RTL
====================

Name: spmv_row_feeder

Overview:
- Producer-side front end for the SpMV dot-product kernel.
- Converts a CSR row-pointer stream into per-row element counts on the TIMES stream.
- Splits a paired element stream {x, val} into the independent A and B operand streams that the dot kernel consumes.
- Sits between the CSR/x-vector fetch logic and the dot-product kernel; one job per start pulse; done pulse when all rows and elements have been handed off.

Parameters:
- PTR_W, 32, row-pointer and TIMES width.
- DATA_W, 64, FP64 operand width; element input is 2*DATA_W.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle job start; honoured only in IDLE
- num_rows  in  PTR_W  rows in job; sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky pointer-decrease flag; cleared on next accepted start
- S_AXIS_PTR_tdata/tvalid/tready  in/in/out  PTR_W/1/1  CSR row pointers; num_rows+1 words per job
- S_AXIS_ELEM_tdata/tvalid/tready  in/in/out  2*DATA_W/1/1  [DATA_W-1:0]=matrix value, [2*DATA_W-1:DATA_W]=x value
- M_AXIS_A_tdata/tvalid/tready  out/out/in  DATA_W/1/1  matrix values
- M_AXIS_B_tdata/tvalid/tready  out/out/in  DATA_W/1/1  x values
- M_AXIS_TIMES_tdata/tvalid/tready  out/out/in  PTR_W/1/1  elements in each row

Behaviour:
- Reset:
  - FSM to IDLE.
  - All tvalid, tready, busy, done and err = 0.
  - Counters = 0.
- Clocking: single clock domain.
- AXIS rules: all outputs are registered; tvalid never drops without a handshake; tdata stays stable while valid && !ready.
- FSM states:
  - IDLE:
    - start with num_rows!=0: latch rows_left=num_rows, clear nnz_pending, clear err, busy=1, go to BASE.
    - start with num_rows==0: done pulses next cycle; stays IDLE; busy stays 0.
  - BASE: PTR_tready=1; on handshake prev=tdata, go to ROWS.
  - ROWS:
    - PTR_tready = !TIMES_tvalid || TIMES_tready (single output register, no bubble).
    - On handshake: len = tdata - prev (unsigned, PTR_W bits).
    - If tdata < prev: len forced to 0 and err set.
    - Load TIMES register with len; nnz_pending += len; prev = tdata; rows_left--.
    - rows_left reaching 0 -> DRAIN.
  - DRAIN:
    - PTR_tready=0.
    - When TIMES_tvalid=0, nnz_pending=0, A_tvalid=0 and B_tvalid=0: done pulses for 1 cycle, busy=0, go to IDLE.
- Element path (independent of FSM state):
  - ELEM_tready = (nnz_pending!=0) && (!A_tvalid || A_tready) && (!B_tvalid || B_tready).
  - Accept loads both A and B registers.
  - A and B clear independently on their own handshakes.
  - Sustains 1 element/cycle when both sinks are ready.
- Counter update: if a row-pointer handshake and an element accept happen in the same cycle, nnz_pending += len - 1.
- Ordering: elements of row k are never accepted before row k's pointer has been consumed. Excess elements are back-pressured (tready=0). Missing elements stall the job indefinitely; there is no timeout.
- Latency: ptr handshake -> TIMES_tvalid 1 cycle; elem handshake -> A/B tvalid 1 cycle.
- Empty rows: TIMES=0 is emitted; no elements are consumed for them.
- Wrap-around: the nnz_pending width is PTR_W; a total nnz per job ≥ 2^PTR_W is unsupported.
- start while busy: ignored.
- Reset mid-job: all in-flight data is discarded; outputs invalid on the next edge.

Decomposition:
- Shared package spmv_feed_pkg:
  - PTR_W and DATA_W defaults.
  - State enum {IDLE, BASE, ROWS, DRAIN}.
  - Element field slice constants.
- Sub-module axis_fork2: one input, two independently registered outputs, ready rule as above. Reused for any other operand split.

Test Plan:
- start, num_rows=3; ptrs 10,13,13,18; 8 elems, A/B always ready -> TIMES 3,0,5; A/B each carry 8 words in order; done 1 cycle after the last A/B handshake; err=0.
- Same job with B_tready low for cycles 5-9 -> A holds at most 1 word ahead; ELEM_tready=0 while B is full; no data loss; identical output order.
- ptrs 20,15,17 with num_rows=2 -> TIMES 0,2; err=1 and stays set until the next start; 2 elems consumed; done.
- num_rows=0 start -> done next cycle; no ptr/elem tready asserted; busy stays 0.
- Elements offered before the second pointer -> ELEM_tready=0 until the first row's TIMES is loaded; then exactly len elements are accepted, followed by back-pressure.
- Assert rstn low mid-ROWS with TIMES_tvalid=1 -> all tvalid=0 and busy=0 immediately; a new job afterwards runs correctly.

Source files
------------

// File: rtl/spmv_row_feeder_pkg.sv
// ---------------------------------------------------------------------------
// spmv_feed_pkg: shared widths, FSM encoding and element field slots. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spmv_feed_pkg;

  localparam int PTR_W_DEF  = 32;
  localparam int DATA_W_DEF = 64;

  typedef logic [1:0] feed_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BASE  = 2'd1;
  localparam logic [1:0] ST_ROWS  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Element word is {x, val}; slot index times DATA_W gives the field LSB.
  localparam int ELEM_VAL_SLOT = 0;
  localparam int ELEM_X_SLOT   = 1;

endpackage

`default_nettype wire

// File: rtl/spmv_row_feeder_axis_fork2.sv
// ---------------------------------------------------------------------------
// axis_fork2: one AXIS input split into two independently registered outputs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_fork2 #(
  parameter int W_A = 64,
  parameter int W_B = 64
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           i_enable,
  input  logic [W_A-1:0] i_s_a_data,
  input  logic [W_B-1:0] i_s_b_data,
  input  logic           i_s_valid,
  output logic           o_s_ready,
  output logic           o_s_hs,
  output logic [W_A-1:0] o_m_a_data,
  output logic           o_m_a_valid,
  input  logic           i_m_a_ready,
  output logic [W_B-1:0] o_m_b_data,
  output logic           o_m_b_valid,
  input  logic           i_m_b_ready
);

  logic [W_A-1:0] r_a_data;
  logic [W_B-1:0] r_b_data;
  logic           r_a_valid;
  logic           r_b_valid;
  logic           w_a_free;
  logic           w_b_free;
  logic           w_s_ready;
  logic           w_s_hs;

  // An input word is only taken when both output slots can hold it, so the
  // two halves of a word always leave in the same relative order.
  assign w_a_free  = !r_a_valid || i_m_a_ready;
  assign w_b_free  = !r_b_valid || i_m_b_ready;
  assign w_s_ready = i_enable && w_a_free && w_b_free;
  assign w_s_hs    = i_s_valid && w_s_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a_data  <= '0;
      r_b_data  <= '0;
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
    end else begin
      if (w_s_hs) begin
        r_a_data  <= i_s_a_data;
        r_a_valid <= 1'b1;
      end else if (i_m_a_ready) begin
        r_a_valid <= 1'b0;
      end
      if (w_s_hs) begin
        r_b_data  <= i_s_b_data;
        r_b_valid <= 1'b1;
      end else if (i_m_b_ready) begin
        r_b_valid <= 1'b0;
      end
    end
  end

  assign o_s_ready   = w_s_ready;
  assign o_s_hs      = w_s_hs;
  assign o_m_a_data  = r_a_data;
  assign o_m_a_valid = r_a_valid;
  assign o_m_b_data  = r_b_data;
  assign o_m_b_valid = r_b_valid;

endmodule

`default_nettype wire

// File: rtl/spmv_row_feeder.sv
// ---------------------------------------------------------------------------
// spmv_row_feeder: CSR row pointers to per-row TIMES, {x,val} split to A/B. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spmv_row_feeder
  import spmv_feed_pkg::*;
#(
  parameter int PTR_W  = PTR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [PTR_W-1:0]    num_rows,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [PTR_W-1:0]    S_AXIS_PTR_tdata,
  input  logic                S_AXIS_PTR_tvalid,
  output logic                S_AXIS_PTR_tready,
  input  logic [2*DATA_W-1:0] S_AXIS_ELEM_tdata,
  input  logic                S_AXIS_ELEM_tvalid,
  output logic                S_AXIS_ELEM_tready,
  output logic [DATA_W-1:0]   M_AXIS_A_tdata,
  output logic                M_AXIS_A_tvalid,
  input  logic                M_AXIS_A_tready,
  output logic [DATA_W-1:0]   M_AXIS_B_tdata,
  output logic                M_AXIS_B_tvalid,
  input  logic                M_AXIS_B_tready,
  output logic [PTR_W-1:0]    M_AXIS_TIMES_tdata,
  output logic                M_AXIS_TIMES_tvalid,
  input  logic                M_AXIS_TIMES_tready
);

  feed_state_t      r_state;
  logic [PTR_W-1:0] r_rows_left;
  logic [PTR_W-1:0] r_prev;
  logic [PTR_W-1:0] r_nnz;
  logic [PTR_W-1:0] r_times_data;
  logic             r_times_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_times_free;
  logic             w_ptr_ready;
  logic             w_ptr_hs;
  logic             w_row_hs;
  logic             w_ptr_dec;
  logic [PTR_W-1:0] w_len;
  logic [PTR_W-1:0] w_add;
  logic [PTR_W-1:0] w_sub;
  logic [PTR_W-1:0] w_nnz_next;
  logic             w_elem_hs;
  logic             w_a_valid;
  logic             w_b_valid;
  logic             w_drained;

  assign w_times_free = !r_times_valid || M_AXIS_TIMES_tready;
  assign w_ptr_ready  = (r_state == ST_BASE) || ((r_state == ST_ROWS) && w_times_free);
  assign w_ptr_hs     = S_AXIS_PTR_tvalid && w_ptr_ready;
  assign w_row_hs     = w_ptr_hs && (r_state == ST_ROWS);

  // A decreasing pointer is malformed CSR: emit an empty row and flag it.
  assign w_ptr_dec = S_AXIS_PTR_tdata < r_prev;
  assign w_len     = w_ptr_dec ? '0 : (S_AXIS_PTR_tdata - r_prev);

  assign w_add      = w_row_hs ? w_len : '0;
  assign w_sub      = {{(PTR_W-1){1'b0}}, w_elem_hs};
  assign w_nnz_next = r_nnz + w_add - w_sub;

  assign w_drained = !r_times_valid && (r_nnz == '0) && !w_a_valid && !w_b_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_rows_left   <= '0;
      r_prev        <= '0;
      r_nnz         <= '0;
      r_times_data  <= '0;
      r_times_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_nnz  <= w_nnz_next;

      if (w_row_hs) begin
        r_times_data  <= w_len;
        r_times_valid <= 1'b1;
      end else if (M_AXIS_TIMES_tready) begin
        r_times_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_err <= 1'b0;
            if (num_rows != '0) begin
              r_rows_left <= num_rows;
              r_nnz       <= '0;
              r_busy      <= 1'b1;
              r_state     <= ST_BASE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_BASE: begin
          if (w_ptr_hs) begin
            r_prev  <= S_AXIS_PTR_tdata;
            r_state <= ST_ROWS;
          end
        end
        ST_ROWS: begin
          if (w_row_hs) begin
            r_prev      <= S_AXIS_PTR_tdata;
            r_rows_left <= r_rows_left - 1'b1;
            if (w_ptr_dec) begin
              r_err <= 1'b1;
            end
            if (r_rows_left == PTR_W'(1)) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Elements flow only against row lengths already registered, which keeps
  // every element behind the pointer that announced it.
  axis_fork2 #(
    .W_A (DATA_W),
    .W_B (DATA_W)
  ) u_fork (
    .clk         (clk),
    .rstn        (rstn),
    .i_enable    (r_nnz != '0),
    .i_s_a_data  (S_AXIS_ELEM_tdata[ELEM_VAL_SLOT*DATA_W +: DATA_W]),
    .i_s_b_data  (S_AXIS_ELEM_tdata[ELEM_X_SLOT*DATA_W +: DATA_W]),
    .i_s_valid   (S_AXIS_ELEM_tvalid),
    .o_s_ready   (S_AXIS_ELEM_tready),
    .o_s_hs      (w_elem_hs),
    .o_m_a_data  (M_AXIS_A_tdata),
    .o_m_a_valid (w_a_valid),
    .i_m_a_ready (M_AXIS_A_tready),
    .o_m_b_data  (M_AXIS_B_tdata),
    .o_m_b_valid (w_b_valid),
    .i_m_b_ready (M_AXIS_B_tready)
  );

  assign M_AXIS_A_tvalid     = w_a_valid;
  assign M_AXIS_B_tvalid     = w_b_valid;
  assign S_AXIS_PTR_tready   = w_ptr_ready;
  assign M_AXIS_TIMES_tdata  = r_times_data;
  assign M_AXIS_TIMES_tvalid = r_times_valid;
  assign busy                = r_busy;
  assign done                = r_done;
  assign err                 = r_err;

endmodule

`default_nettype wire
